// File: rtl/pe_grid_pkg.sv
// Shared types and lane-format helpers for the PE grid west-edge feeder.
package pe_grid_pkg;

  // Feeder control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feed_state_e;

  // Default lane format: valid bit on top of a DATA_W element
  localparam int unsigned DATA_W_DFLT  = 8;
  localparam int unsigned LANE_W       = DATA_W_DFLT + 1;
  localparam int unsigned LANE_VLD_BIT = DATA_W_DFLT;

  // Lane width for an arbitrary element width
  function automatic int unsigned lane_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // Valid-bit position inside a lane for an arbitrary element width
  function automatic int unsigned lane_vld_bit(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/pe_feed_fifo.sv
// Synchronous vector FIFO with registered full/empty flags and exact occupancy.
module pe_feed_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Full blocks a push even when a pop happens in the same cycle
  assign push_ok = i_push && !full_q;
  assign pop_ok  = i_pop  && !empty_q;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/pe_grid_feeder.sv
// West-edge feeder: buffers activation vectors, streams a programmed count
// onto the grid with a per-row diagonal skew, then drains and reports done.
module pe_grid_feeder
  import pe_grid_pkg::*;
#(
  parameter int unsigned ROWS   = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [LEN_W-1:0]               i_len,
  output logic                           o_busy,
  output logic                           o_done,
  input  logic                           i_vec_valid,
  output logic                           o_vec_ready,
  input  logic [ROWS*DATA_W-1:0]         i_vec_data,
  output logic [ROWS*(DATA_W+1)-1:0]     o_west_data,
  output logic [$clog2(DEPTH):0]         o_fifo_count
);

  localparam int unsigned VEC_W = ROWS * DATA_W;
  localparam int unsigned LN_W  = lane_w(DATA_W);
  localparam int unsigned FL_W  = $clog2(ROWS) + 1;

  feed_state_e      state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic             busy_q, done_q;
  logic             issue_c;

  logic [VEC_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;

  pe_feed_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_vec_valid),
    .i_wdata (i_vec_data),
    .i_pop   (issue_c),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_fifo_count)
  );

  // Ready comes straight from the registered full flag
  assign o_vec_ready = !fifo_full;

  // Next-state, remaining/flush counters and pop decision
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fl_d    = fl_q;
    issue_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = i_len;
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (!fifo_empty && (rem_q != '0)) begin
          issue_c = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_FLUSH;
            fl_d    = FL_W'(ROWS - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (fl_q == '0) state_d = ST_DONE;
        else            fl_d    = fl_q - FL_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      fl_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fl_q    <= fl_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

  // Per-row skew: row r sees its element r+1 cycles after issue
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] elem_c;
    logic [LN_W-1:0]   pipe_q [r+1];

    // Bubbles carry zero data so idle lanes never show stale elements
    assign elem_c = issue_c ? fifo_rdata[(ROWS-r)*DATA_W-1 -: DATA_W] : '0;

    // Row r delay line: stage 0 captures the issue, stage r drives the lane
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int k = 0; k <= r; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= {issue_c, elem_c};
        for (int k = 1; k <= r; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign o_west_data[(ROWS-r)*LN_W-1 -: LN_W] = pipe_q[r];
  end

endmodule

// File: tb/tb_pe_grid_feeder.sv
// Directed bench for the west-edge feeder (3 rows, 8-bit elements, depth 4).
module tb_pe_grid_feeder;

  localparam int unsigned ROWS   = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned LW     = DATA_W + 1;

  logic                   i_clk;
  logic                   i_rst;
  logic                   i_start;
  logic [LEN_W-1:0]       i_len;
  logic                   o_busy;
  logic                   o_done;
  logic                   i_vec_valid;
  logic                   o_vec_ready;
  logic [ROWS*DATA_W-1:0] i_vec_data;
  logic [ROWS*LW-1:0]     o_west_data;
  logic [2:0]             o_fifo_count;

  int n_checks;
  int n_fail;

  pe_grid_feeder #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_len        (i_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_vec_valid  (i_vec_valid),
    .o_vec_ready  (o_vec_ready),
    .i_vec_data   (i_vec_data),
    .o_west_data  (o_west_data),
    .o_fifo_count (o_fifo_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [LW-1:0] lane(input int r);
    return o_west_data[(ROWS-r)*LW-1 -: LW];
  endfunction

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    tick;
    tick;
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL rst_west got=%h exp=0", o_west_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", o_done); end
    n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", o_fifo_count); end
    i_rst = 1'b0;
    tick;
    n_checks++; if (o_vec_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", o_vec_ready); end
  endtask

  task automatic test_prefill_stream;
    i_vec_valid = 1'b1; i_vec_data = 24'h112233; tick;
    i_vec_data = 24'h445566; tick;
    i_vec_valid = 1'b0;
    n_checks++; if (o_fifo_count !== 3'd2) begin n_fail++; $display("FAIL pf_count got=%0d exp=2", o_fifo_count); end
    i_start = 1'b1; i_len = 16'd2;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL pf_busy_c1 got=%b exp=1", o_busy); end
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL pf_west_c1 got=%h exp=0", o_west_data); end
    tick;                                      // cycle 2
    n_checks++; if (lane(0) !== 9'h111) begin n_fail++; $display("FAIL pf_r0_c2 got=%h exp=111", lane(0)); end
    tick;                                      // cycle 3
    n_checks++; if (lane(0) !== 9'h144) begin n_fail++; $display("FAIL pf_r0_c3 got=%h exp=144", lane(0)); end
    n_checks++; if (lane(1) !== 9'h122) begin n_fail++; $display("FAIL pf_r1_c3 got=%h exp=122", lane(1)); end
    tick;                                      // cycle 4
    n_checks++; if (lane(0) !== 9'h000) begin n_fail++; $display("FAIL pf_r0_c4 got=%h exp=000", lane(0)); end
    n_checks++; if (lane(1) !== 9'h155) begin n_fail++; $display("FAIL pf_r1_c4 got=%h exp=155", lane(1)); end
    n_checks++; if (lane(2) !== 9'h133) begin n_fail++; $display("FAIL pf_r2_c4 got=%h exp=133", lane(2)); end
    tick;                                      // cycle 5
    n_checks++; if (lane(2) !== 9'h166) begin n_fail++; $display("FAIL pf_r2_c5 got=%h exp=166", lane(2)); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL pf_done_c5 got=%b exp=0", o_done); end
    tick;                                      // cycle 6
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL pf_done_c6 got=%b exp=1", o_done); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL pf_busy_c6 got=%b exp=1", o_busy); end
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL pf_west_c6 got=%h exp=0", o_west_data); end
    tick;                                      // cycle 7
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL pf_busy_c7 got=%b exp=0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL pf_done_c7 got=%b exp=0", o_done); end
    n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL pf_count_c7 got=%0d exp=0", o_fifo_count); end
  endtask

  task automatic test_starvation;
    i_vec_valid = 1'b1; i_vec_data = 24'hAABBCC; tick;
    i_vec_valid = 1'b0;
    i_start = 1'b1; i_len = 16'd2;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1
    tick;                                      // cycle 2
    n_checks++; if (lane(0) !== 9'h1AA) begin n_fail++; $display("FAIL sv_r0_c2 got=%h exp=1aa", lane(0)); end
    tick;                                      // cycle 3: late vector arrives
    i_vec_valid = 1'b1; i_vec_data = 24'hDDEEFF;
    n_checks++; if (lane(0) !== 9'h000) begin n_fail++; $display("FAIL sv_r0_c3 got=%h exp=000", lane(0)); end
    n_checks++; if (lane(1) !== 9'h1BB) begin n_fail++; $display("FAIL sv_r1_c3 got=%h exp=1bb", lane(1)); end
    tick;                                      // cycle 4
    i_vec_valid = 1'b0;
    n_checks++; if (lane(0) !== 9'h000) begin n_fail++; $display("FAIL sv_r0_c4 got=%h exp=000", lane(0)); end
    n_checks++; if (lane(2) !== 9'h1CC) begin n_fail++; $display("FAIL sv_r2_c4 got=%h exp=1cc", lane(2)); end
    n_checks++; if (o_fifo_count !== 3'd1) begin n_fail++; $display("FAIL sv_count_c4 got=%0d exp=1", o_fifo_count); end
    tick;                                      // cycle 5
    n_checks++; if (lane(0) !== 9'h1DD) begin n_fail++; $display("FAIL sv_r0_c5 got=%h exp=1dd", lane(0)); end
    n_checks++; if (lane(1) !== 9'h000) begin n_fail++; $display("FAIL sv_r1_c5 got=%h exp=000", lane(1)); end
    tick;                                      // cycle 6
    n_checks++; if (lane(1) !== 9'h1EE) begin n_fail++; $display("FAIL sv_r1_c6 got=%h exp=1ee", lane(1)); end
    n_checks++; if (lane(2) !== 9'h000) begin n_fail++; $display("FAIL sv_r2_c6 got=%h exp=000", lane(2)); end
    tick;                                      // cycle 7
    n_checks++; if (lane(2) !== 9'h1FF) begin n_fail++; $display("FAIL sv_r2_c7 got=%h exp=1ff", lane(2)); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL sv_done_c7 got=%b exp=0", o_done); end
    tick;                                      // cycle 8
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL sv_done_c8 got=%b exp=1", o_done); end
    tick;
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL sv_busy_c9 got=%b exp=0", o_busy); end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (o_vec_ready !== (k < 4)) begin n_fail++; $display("FAIL bp_ready_push%0d got=%b exp=%b", k, o_vec_ready, (k < 4)); end
      i_vec_valid = 1'b1;
      i_vec_data  = {3{8'(k + 1)}};
      tick;
    end
    n_checks++; if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count_full got=%0d exp=4", o_fifo_count); end
    n_checks++; if (o_vec_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b exp=0", o_vec_ready); end
    // Keep pushing while a one-vector stream pops from the full FIFO
    i_vec_data = 24'h777777;
    i_start = 1'b1; i_len = 16'd1;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1: pop while full
    n_checks++; if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count_c1 got=%0d exp=4", o_fifo_count); end
    tick;                                      // cycle 2
    i_vec_valid = 1'b0;
    n_checks++; if (o_fifo_count !== 3'd3) begin n_fail++; $display("FAIL bp_count_c2 got=%0d exp=3", o_fifo_count); end
    n_checks++; if (lane(0) !== 9'h101) begin n_fail++; $display("FAIL bp_r0_c2 got=%h exp=101", lane(0)); end
    n_checks++; if (o_vec_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_c2 got=%b exp=1", o_vec_ready); end
    tick; tick; tick;                          // cycle 5
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL bp_done_c5 got=%b exp=1", o_done); end
    tick;                                      // cycle 6
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_c6 got=%b exp=0", o_busy); end
    n_checks++; if (o_fifo_count !== 3'd3) begin n_fail++; $display("FAIL bp_count_c6 got=%0d exp=3", o_fifo_count); end
  endtask

  task automatic test_reset_mid;
    i_start = 1'b1; i_len = 16'd3;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1
    tick;                                      // cycle 2
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_c2 got=%b exp=1", o_busy); end
    n_checks++; if (lane(0) !== 9'h102) begin n_fail++; $display("FAIL rm_r0_c2 got=%h exp=102", lane(0)); end
    i_rst = 1'b1;
    tick;                                      // cycle 3
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_c3 got=%b exp=0", o_busy); end
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL rm_west_c3 got=%h exp=0", o_west_data); end
    n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rm_count_c3 got=%0d exp=0", o_fifo_count); end
    i_rst = 1'b0;
    tick;
    n_checks++; if (o_vec_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got=%b exp=1", o_vec_ready); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_after got=%b exp=0", o_busy); end
  endtask

  task automatic test_zero_len;
    i_start = 1'b1; i_len = 16'd0;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL zl_done_c1 got=%b exp=1", o_done); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL zl_busy_c1 got=%b exp=1", o_busy); end
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL zl_west_c1 got=%h exp=0", o_west_data); end
    tick;                                      // cycle 2
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL zl_done_c2 got=%b exp=0", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL zl_busy_c2 got=%b exp=0", o_busy); end
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL zl_west_c2 got=%h exp=0", o_west_data); end
  endtask

  task automatic test_ignored_start;
    i_vec_valid = 1'b1; i_vec_data = 24'hC1C2C3; tick;
    i_vec_data = 24'hD1D2D3; tick;
    i_vec_valid = 1'b0;
    i_start = 1'b1; i_len = 16'd2;             // cycle 0
    tick; i_len = 16'd9;                       // cycle 1: start held high while busy
    tick; i_start = 1'b0;                      // cycle 2
    n_checks++; if (lane(0) !== 9'h1C1) begin n_fail++; $display("FAIL ig_r0_c2 got=%h exp=1c1", lane(0)); end
    tick;                                      // cycle 3
    n_checks++; if (lane(0) !== 9'h1D1) begin n_fail++; $display("FAIL ig_r0_c3 got=%h exp=1d1", lane(0)); end
    tick; tick;                                // cycle 5
    n_checks++; if (lane(2) !== 9'h1D3) begin n_fail++; $display("FAIL ig_r2_c5 got=%h exp=1d3", lane(2)); end
    tick;                                      // cycle 6
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL ig_done_c6 got=%b exp=1", o_done); end
    tick;                                      // cycle 7
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ig_busy_c7 got=%b exp=0", o_busy); end
  endtask

  task automatic test_back_to_back;
    i_vec_valid = 1'b1;
    i_vec_data = 24'h102030; tick;
    i_vec_data = 24'h405060; tick;
    i_vec_data = 24'h708090; tick;
    i_vec_data = 24'hA0B0C0; tick;
    i_vec_valid = 1'b0;
    n_checks++; if (o_fifo_count !== 3'd4) begin n_fail++; $display("FAIL bb_count got=%0d exp=4", o_fifo_count); end
    i_start = 1'b1; i_len = 16'd2;             // cycle 0
    tick; i_start = 1'b0;                      // cycle 1
    tick;                                      // cycle 2
    n_checks++; if (lane(0) !== 9'h110) begin n_fail++; $display("FAIL bb_s1_r0_c2 got=%h exp=110", lane(0)); end
    tick; tick; tick;                          // cycle 5
    n_checks++; if (lane(2) !== 9'h160) begin n_fail++; $display("FAIL bb_s1_r2_c5 got=%h exp=160", lane(2)); end
    tick;                                      // cycle 6
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL bb_s1_done got=%b exp=1", o_done); end
    tick;                                      // cycle 7: restart right after done
    i_start = 1'b1; i_len = 16'd2;
    n_checks++; if (o_west_data !== '0) begin n_fail++; $display("FAIL bb_gap_west got=%h exp=0", o_west_data); end
    tick; i_start = 1'b0;                      // cycle 8
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL bb_s2_busy got=%b exp=1", o_busy); end
    tick;                                      // cycle 9
    n_checks++; if (lane(0) !== 9'h170) begin n_fail++; $display("FAIL bb_s2_r0_c9 got=%h exp=170", lane(0)); end
    tick;                                      // cycle 10
    n_checks++; if (lane(0) !== 9'h1A0) begin n_fail++; $display("FAIL bb_s2_r0_c10 got=%h exp=1a0", lane(0)); end
    n_checks++; if (lane(1) !== 9'h180) begin n_fail++; $display("FAIL bb_s2_r1_c10 got=%h exp=180", lane(1)); end
    tick;                                      // cycle 11
    n_checks++; if (lane(1) !== 9'h1B0) begin n_fail++; $display("FAIL bb_s2_r1_c11 got=%h exp=1b0", lane(1)); end
    n_checks++; if (lane(2) !== 9'h190) begin n_fail++; $display("FAIL bb_s2_r2_c11 got=%h exp=190", lane(2)); end
    tick;                                      // cycle 12
    n_checks++; if (lane(2) !== 9'h1C0) begin n_fail++; $display("FAIL bb_s2_r2_c12 got=%h exp=1c0", lane(2)); end
    tick;                                      // cycle 13
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL bb_s2_done got=%b exp=1", o_done); end
    tick;                                      // cycle 14
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bb_s2_busy_end got=%b exp=0", o_busy); end
    n_checks++; if (o_fifo_count !== 3'd0) begin n_fail++; $display("FAIL bb_count_end got=%0d exp=0", o_fifo_count); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_len       = '0;
    i_vec_valid = 1'b0;
    i_vec_data  = '0;
    test_reset;
    test_prefill_stream;
    test_starvation;
    test_backpressure;
    test_reset_mid;
    test_zero_len;
    test_ignored_start;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
